// File: rtl/fetch_queue.sv
// fetch_queue: owns the fetch PC, drives instruction memory, buffers fetched words in a prefetch FIFO.
// Redirects flush the FIFO and restart fetch at the aligned target.
module fetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   fetch_en,
    output logic [31:0]            imem_a,
    input  logic [31:0]            imem_rd,
    input  logic                   redirect,
    input  logic [31:0]            redirect_pc,
    output logic                   instr_valid,
    input  logic                   instr_ready,
    output logic [31:0]            instr,
    output logic [31:0]            instr_pc,
    output logic [31:0]            instr_pc8,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    logic [31:0]   fetch_pc;
    logic [31:0]   pc_mem  [DEPTH];
    logic [31:0]   ins_mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic          push, pop;
    assign imem_a      = {fetch_pc[31:2], 2'b00};
    assign instr_valid = count != '0;
    assign pop         = instr_valid & instr_ready;
    // a full queue still accepts a word when the head leaves in the same cycle
    assign push        = fetch_en & ~redirect & ((count < FULL) | pop);
    assign instr       = instr_valid ? ins_mem[rd_ptr] : '0;
    assign instr_pc    = instr_valid ? pc_mem[rd_ptr] : '0;
    assign instr_pc8   = instr_valid ? pc_mem[rd_ptr] + 32'd8 : '0;
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]  <= fetch_pc;
            ins_mem[wr_ptr] <= imem_rd;
        end
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_pc <= RESET_PC & ~32'd3;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else if (redirect) begin
            fetch_pc <= redirect_pc & ~32'd3;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            if (push) begin
                wr_ptr   <= wr_ptr + AW'(1);
                fetch_pc <= fetch_pc + 32'd4;
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: scenario tasks plus randomized run against a queue-based fetch model.
module tb_fetch_queue;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n, reset_n2, fetch_en, redirect, instr_ready, no_redirect;
    logic [31:0] redirect_pc, mem_base, zero_pc;
    logic [31:0] imem_a, imem_rd, instr, instr_pc, instr_pc8;
    logic [31:0] imem_a2, imem_rd2, instr2, instr_pc2, instr_pc8_2;
    logic        instr_valid, instr_valid2;
    logic [2:0]  count, count2;

    assign imem_rd  = mem_base + (imem_a >> 2);
    assign imem_rd2 = mem_base + (imem_a2 >> 2);

    fetch_queue dut (
        .clk(clk), .reset_n(reset_n), .fetch_en(fetch_en), .imem_a(imem_a), .imem_rd(imem_rd),
        .redirect(redirect), .redirect_pc(redirect_pc), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc), .instr_pc8(instr_pc8),
        .count(count)
    );

    fetch_queue #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(4)) dut2 (
        .clk(clk), .reset_n(reset_n2), .fetch_en(fetch_en), .imem_a(imem_a2), .imem_rd(imem_rd2),
        .redirect(no_redirect), .redirect_pc(zero_pc), .instr_valid(instr_valid2),
        .instr_ready(instr_ready), .instr(instr2), .instr_pc(instr_pc2), .instr_pc8(instr_pc8_2),
        .count(count2)
    );

    typedef struct { logic [31:0] pc; logic [31:0] w; } ent_t;
    ent_t        mq[$];
    logic [31:0] mpc;
    int          checks = 0, errors = 0;

    logic [131:0] got;
    assign got = {instr_valid, count, imem_a, instr, instr_pc, instr_pc8};

    function automatic logic [131:0] expv();
        if (mq.size() == 0) return {1'b0, 3'd0, mpc, 96'd0};
        return {1'b1, 3'(mq.size()), mpc, mq[0].w, mq[0].pc, mq[0].pc + 32'd8};
    endfunction

    task automatic step();
        ent_t e;
        bit   pop, push;
        if (redirect) begin
            mq.delete();
            mpc = redirect_pc & ~32'd3;
        end else begin
            pop  = (mq.size() != 0) && instr_ready;
            push = fetch_en && (mq.size() < 4 || pop);
            e.pc = mpc;
            e.w  = mem_base + (mpc >> 2);
            if (pop) void'(mq.pop_front());
            if (push) begin
                mq.push_back(e);
                mpc = mpc + 32'd4;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #2;
        mq.delete();
        mpc = 32'h0;
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        fetch_en = 1'b1; instr_ready = 1'b1; redirect = 1'b0;
        reset_n = 1'b0;
        #2;
        checks++;
        if (got !== {1'b0, 3'd0, 32'h0, 96'd0}) begin
            errors++;
            $display("FAIL reset_state: got %h exp %h", got, {1'b0, 3'd0, 32'h0, 96'd0});
        end
        mq.delete();
        mpc = 32'h0;
        reset_n = 1'b1;
    endtask

    task automatic test_stream();
        mem_base = 32'hE000_0000; fetch_en = 1'b1; instr_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            checks++;
            if (!instr_valid || instr_pc !== 32'(4 * i) || instr !== 32'hE000_0000 + 32'(i)
                || instr_pc8 !== 32'(4 * i + 8)) begin
                errors++;
                $display("FAIL stream[%0d]: got v %b pc %h instr %h pc8 %h exp pc %h instr %h",
                         i, instr_valid, instr_pc, instr, instr_pc8, 32'(4 * i), 32'hE000_0000 + 32'(i));
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        instr_ready = 1'b0; fetch_en = 1'b1;
        for (int i = 0; i < 4; i++) step();
        checks++;
        if (count !== 3'd4 || got !== expv()) begin
            errors++;
            $display("FAIL bp_fill: got count %0d state %h exp count 4 state %h", count, got, expv());
        end
        step(); step();
        checks++;
        if (imem_a !== 32'h10 || count !== 3'd4) begin
            errors++;
            $display("FAIL bp_hold: got imem_a %h count %0d exp 00000010 4", imem_a, count);
        end
        instr_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (!instr_valid || instr_pc !== 32'(4 * k) || count !== 3'd4) begin
                errors++;
                $display("FAIL bp_drain[%0d]: got v %b pc %h count %0d exp pc %h count 4",
                         k, instr_valid, instr_pc, count, 32'(4 * k));
            end
            step();
        end
    endtask

    task automatic test_redirect();
        do_reset();
        instr_ready = 1'b0; fetch_en = 1'b1; mem_base = 32'hE000_0000;
        for (int i = 0; i < 3; i++) step();
        redirect = 1'b1; redirect_pc = 32'h0000_0103; mem_base = 32'h0;
        step();
        redirect = 1'b0;
        checks++;
        if (instr_valid !== 1'b0 || count !== 3'd0 || imem_a !== 32'h100) begin
            errors++;
            $display("FAIL redir_flush: got v %b count %0d imem_a %h exp 0 0 00000100",
                     instr_valid, count, imem_a);
        end
        step();
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h100 || instr !== 32'h40) begin
            errors++;
            $display("FAIL redir_target: got v %b pc %h instr %h exp 1 00000100 00000040",
                     instr_valid, instr_pc, instr);
        end
        redirect = 1'b1; redirect_pc = 32'h200; step();
        redirect_pc = 32'h302; step();
        redirect = 1'b0; step();
        checks++;
        if (instr_pc !== 32'h300 || instr !== 32'hC0 || count !== 3'd1 || got !== expv()) begin
            errors++;
            $display("FAIL redir_b2b: got pc %h instr %h count %0d exp 00000300 000000c0 1",
                     instr_pc, instr, count);
        end
    endtask

    task automatic test_fetch_en();
        logic [31:0] a;
        do_reset();
        instr_ready = 1'b1; fetch_en = 1'b1; mem_base = 32'hE000_0000;
        for (int i = 0; i < 3; i++) step();
        fetch_en = 1'b0;
        a = imem_a;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (imem_a !== a || got !== expv()) begin
                errors++;
                $display("FAIL fen_freeze[%0d]: got imem_a %h state %h exp %h state %h",
                         i, imem_a, got, a, expv());
            end
        end
        checks++;
        if (instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL fen_drain: got valid %b exp 0", instr_valid);
        end
        fetch_en = 1'b1;
        step();
        checks++;
        if (instr_pc !== a || instr !== 32'hE000_0000 + (a >> 2)) begin
            errors++;
            $display("FAIL fen_resume: got pc %h instr %h exp pc %h", instr_pc, instr, a);
        end
    endtask

    task automatic test_wrap();
        instr_ready = 1'b0; fetch_en = 1'b1; redirect = 1'b0; mem_base = 32'h0;
        checks++;
        if (imem_a2 !== 32'hFFFF_FFF8 || instr_valid2 !== 1'b0) begin
            errors++;
            $display("FAIL wrap_reset: got imem_a %h v %b exp fffffff8 0", imem_a2, instr_valid2);
        end
        reset_n2 = 1'b1;
        for (int i = 0; i < 3; i++) step();
        checks++;
        if (count2 !== 3'd3 || instr_pc2 !== 32'hFFFF_FFF8 || instr2 !== 32'h3FFF_FFFE || imem_a2 !== 32'h4) begin
            errors++;
            $display("FAIL wrap_fill: got count %0d pc %h instr %h imem_a %h exp 3 fffffff8 3ffffffe 00000004",
                     count2, instr_pc2, instr2, imem_a2);
        end
        instr_ready = 1'b1;
        step();
        checks++;
        if (instr_pc2 !== 32'hFFFF_FFFC || instr_pc8_2 !== 32'h4) begin
            errors++;
            $display("FAIL wrap_second: got pc %h pc8 %h exp fffffffc 00000004", instr_pc2, instr_pc8_2);
        end
        step();
        checks++;
        if (instr_pc2 !== 32'h0 || instr_valid2 !== 1'b1 || instr_pc8_2 !== 32'h8) begin
            errors++;
            $display("FAIL wrap_third: got v %b pc %h pc8 %h exp 1 00000000 00000008",
                     instr_valid2, instr_pc2, instr_pc8_2);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        instr_ready = 1'b0; fetch_en = 1'b1; mem_base = 32'hE000_0000;
        for (int i = 0; i < 5; i++) step();
        checks++;
        if (count !== 3'd4) begin
            errors++;
            $display("FAIL areset_full: got count %0d exp 4", count);
        end
        #3;
        reset_n = 1'b0;
        #1;
        checks++;
        if (instr_valid !== 1'b0 || count !== 3'd0 || imem_a !== 32'h0 || instr !== 32'h0 || instr_pc !== 32'h0) begin
            errors++;
            $display("FAIL areset_now: got v %b count %0d imem_a %h instr %h pc %h exp all 0",
                     instr_valid, count, imem_a, instr, instr_pc);
        end
        mq.delete();
        mpc = 32'h0;
        #1;
        reset_n = 1'b1;
        step();
        checks++;
        if (got !== expv() || instr_pc !== 32'h0 || count !== 3'd1) begin
            errors++;
            $display("FAIL areset_restart: got %h exp %h", got, expv());
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            fetch_en    = $urandom_range(0, 3) != 0;
            instr_ready = $urandom_range(0, 1) == 1;
            redirect    = $urandom_range(0, 15) == 0;
            redirect_pc = $urandom;
            mem_base    = $urandom;
            step();
            checks++;
            if (got !== expv()) begin
                errors++;
                $display("FAIL random[%0d]: got %h exp %h", i, got, expv());
            end
        end
        redirect = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; reset_n2 = 1'b0; fetch_en = 1'b0; redirect = 1'b0; instr_ready = 1'b0;
        no_redirect = 1'b0; zero_pc = 32'h0; redirect_pc = 32'h0; mem_base = 32'hE000_0000;
        mpc = 32'h0;
        #1;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_fetch_en();
        test_wrap();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
